// File: rtl/beat_detector.sv
// Hysteresis beat detector: threshold qualification with hold count, refractory
// blanking and a saturating beat-to-beat interval measured in valid samples.
module beat_detector #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned REFRACT = 50,
    parameter int unsigned IW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] th_high,
    input  logic [WIDTH-1:0] th_low,
    output logic             over,
    output logic             beat,
    output logic [IW-1:0]    interval,
    output logic             interval_valid
);

    localparam int unsigned HCW = $clog2(HOLD + 1);
    localparam int unsigned RCW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_CONFIRM = 2'd1,
        S_HIGH    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HCW-1:0]  hc_q, hc_d;
    logic [RCW-1:0]  rc_q, rc_d;
    logic [IW-1:0]   sc_q, sc_d;
    logic            have_prev_q, have_prev_d;
    logic            over_q, over_d;
    logic            beat_q, beat_d;
    logic [IW-1:0]   interval_q, interval_d;
    logic            interval_valid_q, interval_valid_d;

    logic            qual;
    logic            elig;
    logic            fire;
    logic [IW:0]     sc_ext;
    logic [IW-1:0]   sc_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_LOW;
            hc_q             <= '0;
            rc_q             <= '0;
            sc_q             <= '0;
            have_prev_q      <= 1'b0;
            over_q           <= 1'b0;
            beat_q           <= 1'b0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            hc_q             <= hc_d;
            rc_q             <= rc_d;
            sc_q             <= sc_d;
            have_prev_q      <= have_prev_d;
            over_q           <= over_d;
            beat_q           <= beat_d;
            interval_q       <= interval_d;
            interval_valid_q <= interval_valid_d;
        end
    end

    // sc+1 saturating; serves both as the next count and as the reported interval
    always_comb begin
        sc_ext = {1'b0, sc_q} + (IW + 1)'(1);
        sc_sat = sc_ext[IW] ? '1 : sc_ext[IW-1:0];
    end

    always_comb begin
        state_d          = state_q;
        hc_d             = hc_q;
        rc_d             = rc_q;
        sc_d             = sc_q;
        have_prev_d      = have_prev_q;
        interval_d       = interval_q;
        beat_d           = 1'b0;
        interval_valid_d = 1'b0;
        qual             = 1'b0;
        elig             = 1'b0;
        fire             = 1'b0;

        if (sample_valid) begin
            qual = sample > th_high;
            elig = rc_q == '0;

            case (state_q)
                S_LOW: begin
                    if (qual && elig) begin
                        if (HOLD == 1) begin
                            fire = 1'b1;
                        end else begin
                            state_d = S_CONFIRM;
                            hc_d    = HCW'(1);
                        end
                    end
                end
                S_CONFIRM: begin
                    if (qual && elig) begin
                        if (hc_q + HCW'(1) == HCW'(HOLD)) begin
                            fire = 1'b1;
                        end else begin
                            hc_d = hc_q + HCW'(1);
                        end
                    end else begin
                        state_d = S_LOW;
                        hc_d    = '0;
                    end
                end
                S_HIGH: begin
                    if (sample < th_low) begin
                        state_d = S_LOW;
                    end
                end
                default: state_d = S_LOW;
            endcase

            rc_d = (rc_q != '0) ? rc_q - RCW'(1) : rc_q;
            sc_d = sc_sat;

            // beat sample: arm refractory window, restart interval count
            if (fire) begin
                state_d     = S_HIGH;
                hc_d        = '0;
                rc_d        = RCW'(REFRACT);
                sc_d        = '0;
                beat_d      = 1'b1;
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    interval_d       = sc_sat;
                    interval_valid_d = 1'b1;
                end
            end
        end

        over_d = state_d == S_HIGH;
    end

    assign over           = over_q;
    assign beat           = beat_q;
    assign interval       = interval_q;
    assign interval_valid = interval_valid_q;

endmodule

// File: tb/tb_beat_detector.sv
// Directed bench for beat_detector: WIDTH=8, HOLD=2, REFRACT=4, IW=8,
// th_high=100, th_low=80.
module tb_beat_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] th_high;
    logic [7:0] th_low;
    logic       over;
    logic       beat;
    logic [7:0] interval;
    logic       interval_valid;

    int n_vec = 0;
    int n_err = 0;

    beat_detector #(
        .WIDTH(8), .HOLD(2), .REFRACT(4), .IW(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .th_high        (th_high),
        .th_low         (th_low),
        .over           (over),
        .beat           (beat),
        .interval       (interval),
        .interval_valid (interval_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // apply one cycle of input; outputs are sampled 1 time unit after the edge
    task automatic step(input logic v, input logic [7:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bo(input string tag, input logic b, input logic o);
        check({tag, ".beat"}, 32'(beat), 32'(b));
        check({tag, ".over"}, 32'(over), 32'(o));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 8'd120);
        step(1'b1, 8'd120);
        step(1'b1, 8'd120);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = 8'd0;
        th_high      = 8'd100;
        th_low       = 8'd80;

        // reset with qualifying samples present
        do_reset();
        check("rst.over", 32'(over), 0);
        check("rst.beat", 32'(beat), 0);
        check("rst.interval", 32'(interval), 0);
        check("rst.ivalid", 32'(interval_valid), 0);
        step(1'b1, 8'd120);
        chk_bo("rst.s1", 1'b0, 1'b0);
        step(1'b1, 8'd120);
        chk_bo("rst.s2", 1'b1, 1'b1);
        check("rst.s2.ivalid", 32'(interval_valid), 0);
        check("rst.s2.interval", 32'(interval), 0);

        // hysteresis
        do_reset();
        step(1'b1, 8'd50);  chk_bo("hys.50", 1'b0, 1'b0);
        step(1'b1, 8'd120); chk_bo("hys.120a", 1'b0, 1'b0);
        step(1'b1, 8'd120); chk_bo("hys.120b", 1'b1, 1'b1);
        step(1'b1, 8'd90);  chk_bo("hys.90a", 1'b0, 1'b1);
        step(1'b1, 8'd90);  chk_bo("hys.90b", 1'b0, 1'b1);
        step(1'b1, 8'd80);  chk_bo("hys.80", 1'b0, 1'b1);
        step(1'b1, 8'd79);  chk_bo("hys.79", 1'b0, 1'b0);

        // glitch rejection
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i % 2 == 0) ? 8'd50 : 8'd120);
            chk_bo($sformatf("glitch.%0d", i), 1'b0, 1'b0);
        end

        // refractory window
        do_reset();
        step(1'b1, 8'd120);
        step(1'b1, 8'd120); chk_bo("ref.k", 1'b1, 1'b1);
        step(1'b1, 8'd79);  chk_bo("ref.k1", 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            step(1'b1, 8'd120);
            chk_bo($sformatf("ref.k%0d", i), 1'b0, 1'b0);
        end
        step(1'b1, 8'd120); chk_bo("ref.k6", 1'b1, 1'b1);
        check("ref.k6.interval", 32'(interval), 6);
        check("ref.k6.ivalid", 32'(interval_valid), 1);
        step(1'b1, 8'd120); chk_bo("ref.k7", 1'b0, 1'b1);
        check("ref.k7.ivalid", 32'(interval_valid), 0);
        check("ref.k7.interval", 32'(interval), 6);

        // interval saturation
        do_reset();
        step(1'b1, 8'd120);
        step(1'b1, 8'd120); chk_bo("sat.first", 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 8'd50);
        chk_bo("sat.quiet", 1'b0, 1'b0);
        step(1'b1, 8'd120);
        step(1'b1, 8'd120); chk_bo("sat.beat", 1'b1, 1'b1);
        check("sat.interval", 32'(interval), 255);
        check("sat.ivalid", 32'(interval_valid), 1);

        // invalid gaps between qualifying samples
        do_reset();
        step(1'b1, 8'd120);
        step(1'b1, 8'd120); chk_bo("gap.first", 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'd50);
        step(1'b1, 8'd120); chk_bo("gap.q1", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd120);
            chk_bo($sformatf("gap.idle%0d", i), 1'b0, 1'b0);
            check($sformatf("gap.idle%0d.ivalid", i), 32'(interval_valid), 0);
        end
        step(1'b1, 8'd120); chk_bo("gap.q2", 1'b1, 1'b1);
        check("gap.interval", 32'(interval), 7);
        check("gap.ivalid", 32'(interval_valid), 1);
        step(1'b0, 8'd0);
        check("gap.pulse.beat", 32'(beat), 0);
        check("gap.pulse.ivalid", 32'(interval_valid), 0);
        check("gap.hold.interval", 32'(interval), 7);
        check("gap.hold.over", 32'(over), 1);

        // reset while in CONFIRM
        do_reset();
        step(1'b1, 8'd50);
        step(1'b1, 8'd120); chk_bo("mid.confirm", 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 8'd120); chk_bo("mid.rst", 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 8'd120); chk_bo("mid.single", 1'b0, 1'b0);
        step(1'b1, 8'd120); chk_bo("mid.second", 1'b1, 1'b1);
        check("mid.ivalid", 32'(interval_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
